// File: rtl/shift_norm_seq.sv
// shift_norm_seq: multi-cycle CLZ / redundant-sign-bit normaliser.
// One binary-search stage (16,8,4,2,1) is resolved per clock.
module shift_norm_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] norm,
  output logic [4:0]       count,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [2:0]       k;
  logic             sm;
  logic [WIDTH-1:0] w;

  logic [4:0]       n;
  logic [4:0]       kbit;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] shifted;
  logic             hit;
  logic             accept;

  assign norm   = w;
  assign accept = start && (state != S_RUN);

  // Stage test: can the top n bits (or n bits under the sign) be shifted out?
  always_comb begin
    n       = 5'd1 << k;
    kbit    = 5'd1 << k;
    top     = ~({WIDTH{1'b1}} >> n);
    flip    = w ^ {WIDTH{w[WIDTH-1]}};
    shifted = w << n;
    hit     = 1'b0;
    if (sm)
      hit = ((flip & (top >> 1)) == '0);
    else
      hit = ((w & top) == '0);
  end

  // Control FSM with registered busy/done and the working register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
      k     <= 3'd0;
      sm    <= 1'b0;
      w     <= '0;
      count <= 5'd0;
      zero  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (accept) begin
            state <= S_RUN;
            k     <= 3'd4;
            sm    <= signed_mode;
            w     <= data;
            count <= 5'd0;
            zero  <= (data == '0);
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (hit) begin
            w     <= shifted;
            count <= count | kbit;
          end
          if (k == 3'd0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            k <= k - 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
